// File: rtl/fixdiv_responder_if.sv
// Start/Ack handshake plus byte-wide memory port between the bench (master) and the
// fixed-point divide responder (slave).
interface fixdiv_responder_if #(
  parameter int unsigned ADDR_W = 8
) ();
  logic              start;
  logic              ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rd_data;
  logic [7:0]        mem_wr_data;
  logic              mem_wr_en;

  modport master (
    output start, mem_rd_data,
    input  ack, mem_addr, mem_wr_data, mem_wr_en
  );

  modport slave (
    input  start, mem_rd_data,
    output ack, mem_addr, mem_wr_data, mem_wr_en
  );
endinterface

// File: rtl/fixdiv_responder.sv
// Fetches a 16-bit dividend and 8-bit divisor from memory, computes the unsigned 16.8
// quotient by 24-step restoring division, and writes the 24-bit result back.
module fixdiv_responder #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned OP_BASE  = 0,
  parameter int unsigned RES_BASE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  fixdiv_responder_if.slave bus
);

  localparam logic [ADDR_W-1:0] OpAddr  = ADDR_W'(OP_BASE);
  localparam logic [ADDR_W-1:0] ResAddr = ADDR_W'(RES_BASE);
  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] AddrTwo = ADDR_W'(2);

  typedef enum logic [3:0] {
    StIdle, StArmed, StLoad0, StLoad1, StLoad2, StDivide, StStore0, StStore1, StStore2, StDone
  } state_e;

  state_e state_q, state_d;

  logic [15:0] dividend_q, dividend_d;
  logic [7:0]  divisor_q, divisor_d;
  logic [7:0]  rem_q, rem_d;
  logic [23:0] num_q, num_d;
  logic [23:0] quot_q, quot_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        ack_q, ack_d;

  logic [8:0]  trial;
  logic [8:0]  divisor_ext;
  logic [23:0] result;

  assign trial       = {rem_q, num_q[23]};
  assign divisor_ext = {1'b0, divisor_q};
  assign result      = (divisor_q == 8'd0) ? 24'hFF_FFFF : quot_q;

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      num_q      <= '0;
      quot_q     <= '0;
      cnt_q      <= '0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      num_q      <= num_d;
      quot_q     <= quot_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
    end
  end

  // Next-state logic; Start overrides everything, aborting any run.
  always_comb begin
    state_d = state_q;
    if (bus.start) begin
      state_d = StArmed;
    end else begin
      unique case (state_q)
        StIdle:   state_d = StIdle;
        StArmed:  state_d = StLoad0;
        StLoad0:  state_d = StLoad1;
        StLoad1:  state_d = StLoad2;
        StLoad2:  state_d = StDivide;
        StDivide: state_d = (cnt_q == 5'd23) ? StStore0 : StDivide;
        StStore0: state_d = StStore1;
        StStore1: state_d = StStore2;
        StStore2: state_d = StDone;
        StDone:   state_d = StDone;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Operand capture and one restoring-division step per DIVIDE cycle.
  always_comb begin
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    num_d      = num_q;
    quot_d     = quot_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      StLoad0: dividend_d[15:8] = bus.mem_rd_data;
      StLoad1: dividend_d[7:0]  = bus.mem_rd_data;
      StLoad2: begin
        divisor_d = bus.mem_rd_data;
        num_d     = {dividend_q, 8'h00};
        rem_d     = '0;
        quot_d    = '0;
        cnt_d     = '0;
      end
      StDivide: begin
        if (trial >= divisor_ext) begin
          // Remainder stays below the divisor, so the difference fits in 8 bits.
          rem_d  = 8'(trial - divisor_ext);
          quot_d = {quot_q[22:0], 1'b1};
        end else begin
          rem_d  = trial[7:0];
          quot_d = {quot_q[22:0], 1'b0};
        end
        num_d = {num_q[22:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
      end
      default: ;
    endcase
  end

  // Memory port decode; writes are gated by Start so an abort lands mid-store cleanly.
  always_comb begin
    bus.mem_addr    = '0;
    bus.mem_wr_data = '0;
    bus.mem_wr_en   = 1'b0;
    ack_d           = (state_d == StDone);
    unique case (state_q)
      StLoad0: bus.mem_addr = OpAddr;
      StLoad1: bus.mem_addr = OpAddr + AddrOne;
      StLoad2: bus.mem_addr = OpAddr + AddrTwo;
      StStore0: begin
        bus.mem_addr    = ResAddr;
        bus.mem_wr_data = result[23:16];
        bus.mem_wr_en   = !bus.start;
      end
      StStore1: begin
        bus.mem_addr    = ResAddr + AddrOne;
        bus.mem_wr_data = result[15:8];
        bus.mem_wr_en   = !bus.start;
      end
      StStore2: begin
        bus.mem_addr    = ResAddr + AddrTwo;
        bus.mem_wr_data = result[7:0];
        bus.mem_wr_en   = !bus.start;
      end
      default: ;
    endcase
  end

  assign bus.ack = ack_q;

endmodule

// File: tb/tb_fixdiv_responder.sv
// Bench for fixdiv_responder: byte memory model, table-driven and randomized runs
// against an arithmetic reference, plus abort and mid-store reset sequences.
module tb_fixdiv_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fixdiv_responder_if #(.ADDR_W(8)) bus ();

  fixdiv_responder #(
    .ADDR_W  (8),
    .OP_BASE (0),
    .RES_BASE(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic       tb_we = 1'b0;
  logic [7:0] tb_addr = 8'd0;
  logic [7:0] tb_data = 8'd0;
  int         wr_cnt = 0;
  int         cyc = 0;
  int         wr_addr [256];
  int         wr_cyc [256];
  int         n_cmp = 0;
  int         n_bad = 0;

  assign bus.mem_rd_data = mem[bus.mem_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_wr_en) begin
      mem[bus.mem_addr]    <= bus.mem_wr_data;
      wr_addr[wr_cnt[7:0]] <= int'(bus.mem_addr);
      wr_cyc[wr_cnt[7:0]]  <= cyc;
      wr_cnt               <= wr_cnt + 1;
    end else if (tb_we) begin
      mem[tb_addr] <= tb_data;
    end
  end

  typedef struct {
    string name;
    int    dvd;
    int    dvs;
    int    exp;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: floor(dividend*256/divisor), all-ones for a zero divisor.
  function automatic int model(input int dvd, input int dvs);
    if (dvs == 0) return 32'h00FF_FFFF;
    return (dvd * 256) / dvs;
  endfunction

  function automatic int res_mem();
    return {8'h00, mem[4], mem[5], mem[6]};
  endfunction

  task automatic tb_write(input logic [7:0] a, input logic [7:0] d);
    tb_we   = 1'b1;
    tb_addr = a;
    tb_data = d;
    @(posedge clk);
    #1;
    tb_we = 1'b0;
  endtask

  // Raise Start, poison the result bytes, load operands; Start stays high on return.
  task automatic arm_and_load(input string name, input int dvd, input int dvs);
    logic [15:0] d16;
    logic [7:0]  s8;
    d16 = dvd[15:0];
    s8  = dvs[7:0];
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    check({name, " ack dropped by start"}, int'(bus.ack), 0);
    tb_write(8'd4, 8'hAA);
    tb_write(8'd5, 8'hAA);
    tb_write(8'd6, 8'hAA);
    tb_write(8'd0, d16[15:8]);
    tb_write(8'd1, d16[7:0]);
    tb_write(8'd2, s8);
  endtask

  task automatic do_run(input string name, input int dvd, input int dvs, input int exp);
    int base;
    int n;
    arm_and_load(name, dvd, dvs);
    base = wr_cnt;
    bus.start = 1'b0;
    @(posedge clk);  // E0: ARMED samples Start low
    for (n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (bus.ack) break;
    end
    check({name, " latency"}, n, 30);
    check({name, " write count"}, wr_cnt - base, 3);
    check({name, " write addr0"}, wr_addr[base[7:0]], 4);
    check({name, " write addr2"}, wr_addr[8'(base + 2)], 6);
    check({name, " write span"}, wr_cyc[8'(base + 2)] - wr_cyc[base[7:0]], 2);
    check({name, " result"}, res_mem(), exp);
  endtask

  initial begin
    int base;
    int dvd;
    int dvs;

    vecs[0] = '{"12800/25", 32'h3200, 32'h19, 32'h02_0000};
    vecs[1] = '{"385/6", 32'h0181, 32'h06, 32'h00_402A};
    vecs[2] = '{"div0", 32'h1234, 32'h00, 32'hFF_FFFF};
    vecs[3] = '{"ffff/1", 32'hFFFF, 32'h01, 32'hFF_FF00};
    vecs[4] = '{"1/ff", 32'h0001, 32'hFF, 32'h00_0001};

    bus.start = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset ack", int'(bus.ack), 0);
    check("reset wr_en", int'(bus.mem_wr_en), 0);
    check("reset addr", int'(bus.mem_addr), 0);
    check("reset wr_data", int'(bus.mem_wr_data), 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle no writes", wr_cnt, 0);

    for (int i = 0; i < 5; i++) do_run(vecs[i].name, vecs[i].dvd, vecs[i].dvs, vecs[i].exp);

    // Abort at DIVIDE cycle 10, hold Start high, then a fresh run.
    arm_and_load("abort", 32'h4321, 32'h07);
    bus.start = 1'b0;
    @(posedge clk);
    repeat (13) @(posedge clk);
    #1;
    bus.start = 1'b1;
    base = wr_cnt;
    repeat (40) @(posedge clk);
    #1;
    check("abort no writes", wr_cnt - base, 0);
    check("abort ack", int'(bus.ack), 0);
    check("abort armed addr", int'(bus.mem_addr), 0);
    check("abort result untouched", res_mem(), 32'hAA_AAAA);
    do_run("after abort", 32'h4321, 32'h07, model(32'h4321, 32'h07));

    for (int i = 0; i < 8; i++) begin
      dvd = int'($urandom_range(0, 65535));
      dvs = (i == 3) ? 0 : int'($urandom_range(0, 255));
      do_run($sformatf("rand%0d %0d/%0d", i, dvd, dvs), dvd, dvs, model(dvd, dvs));
    end

    // Reset while in STORE1: only the first result byte lands.
    dvd = 32'hABCD;
    dvs = 32'h37;
    arm_and_load("rst", dvd, dvs);
    base = wr_cnt;
    bus.start = 1'b0;
    @(posedge clk);
    repeat (28) @(posedge clk);
    #1;
    check("rst store1 wr_en", int'(bus.mem_wr_en), 1);
    rst_n = 1'b0;
    #1;
    check("rst ack", int'(bus.ack), 0);
    check("rst wr_en", int'(bus.mem_wr_en), 0);
    check("rst byte4", int'(mem[4]), (model(dvd, dvs) >> 16) & 255);
    check("rst byte5", int'(mem[5]), 32'hAA);
    check("rst byte6", int'(mem[6]), 32'hAA);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("post rst writes", wr_cnt - base, 1);
    check("post rst ack", int'(bus.ack), 0);
    check("post rst addr", int'(bus.mem_addr), 0);
    do_run("post rst run", 32'h0100, 32'h03, model(32'h0100, 32'h03));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
